// File: rtl/tlc_mon_pkg.sv
// Shared types and helpers for the traffic-light phase monitor.
// Build option: define TLC_MON_STALL_EN to enable the phase stall detector.
package tlc_mon_pkg;

  typedef enum logic [1:0] {
    PH_HG = 2'd0,
    PH_HY = 2'd1,
    PH_FG = 2'd2,
    PH_FY = 2'd3
  } phase_t;

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Bit positions inside the lamps bus {fr_r, fr_y, fr_g, hw_r, hw_y, hw_g}
  localparam int LAMP_HW_G = 0;
  localparam int LAMP_HW_Y = 1;
  localparam int LAMP_HW_R = 2;
  localparam int LAMP_FR_G = 3;
  localparam int LAMP_FR_Y = 4;
  localparam int LAMP_FR_R = 5;

  // Exactly two lamps lit: one on each road
  localparam logic [5:0] CODE_HG = (6'd1 << LAMP_HW_G) | (6'd1 << LAMP_FR_R);
  localparam logic [5:0] CODE_HY = (6'd1 << LAMP_HW_Y) | (6'd1 << LAMP_FR_R);
  localparam logic [5:0] CODE_FG = (6'd1 << LAMP_FR_G) | (6'd1 << LAMP_HW_R);
  localparam logic [5:0] CODE_FY = (6'd1 << LAMP_FR_Y) | (6'd1 << LAMP_HW_R);

  // Legal successor in the cycle HG -> HY -> FG -> FY -> HG
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_HG:   return PH_HY;
      PH_HY:   return PH_FG;
      PH_FG:   return PH_FY;
      default: return PH_HG;
    endcase
  endfunction

  // Minimum dwell for a phase: greens use min_green, yellows min_yellow
  function automatic int min_cycles(input phase_t p, input int min_green,
                                    input int min_yellow);
    if (p == PH_HG || p == PH_FG) return min_green;
    return min_yellow;
  endfunction

endpackage

// File: rtl/tlc_lamp_decode.sv
// Combinational lamp decoder: maps the six lamp bits to a legal flag and phase.
module tlc_lamp_decode
  import tlc_mon_pkg::*;
(
  input  logic [5:0] lamps,
  output logic       legal,
  output logic [1:0] phase
);

  // Only the four exact two-lamp codes are legal; everything else is illegal
  always_comb begin
    legal = 1'b1;
    phase = PH_HG;
    case (lamps)
      CODE_HG: phase = PH_HG;
      CODE_HY: phase = PH_HY;
      CODE_FG: phase = PH_FG;
      CODE_FY: phase = PH_FY;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlc_phase_monitor.sv
// On-chip checker for a traffic-light controller lamp interface.
// Registers the lamps, decodes the phase, times it, checks the sequence
// HG -> HY -> FG -> FY -> HG and keeps sticky error flags.
// Build option: define TLC_MON_STALL_EN to raise err_stall when a phase
// lasts MAX_PHASE cycles; otherwise err_stall is tied low.
module tlc_phase_monitor
  import tlc_mon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int TRANS_W    = 16,
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 3,
  parameter int MAX_PHASE  = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         lamps,
  input  logic               clr,
  output logic               phase_valid,
  output logic [1:0]         phase,
  output logic [CNT_W-1:0]   phase_cycles,
  output logic [TRANS_W-1:0] trans_cnt,
  output logic               err_code,
  output logic               err_seq,
  output logic               err_short,
  output logic               err_stall
);

  localparam logic [CNT_W-1:0] CYC_MAX = '1;
  localparam logic [CNT_W-1:0] CYC_ONE = CNT_W'(1);

  // Parameter sanity: the minimums and stall limit must fit the counter
  if (MIN_GREEN >= (2 ** CNT_W) || MIN_YELLOW >= (2 ** CNT_W) ||
      MAX_PHASE >= (2 ** CNT_W)) begin : g_bad_params
    $error("tlc_phase_monitor: MIN_* and MAX_PHASE must be below 2**CNT_W");
  end

  logic [5:0]         lamps_q;
  logic               dec_legal;
  logic [1:0]         dec_phase_raw;
  phase_t             dec_phase;
  state_t             state, state_n;
  phase_t             phase_r, phase_n;
  logic [CNT_W-1:0]   cyc_n;
  logic [TRANS_W-1:0] trans_n;
  logic               first, first_n;
  logic               valid_n;
  logic               ev_code, ev_seq, ev_short, ev_stall;

  tlc_lamp_decode u_decode (
    .lamps (lamps_q),
    .legal (dec_legal),
    .phase (dec_phase_raw)
  );

  assign dec_phase = phase_t'(dec_phase_raw);
  assign phase     = phase_r;

  // Input capture register
  always_ff @(posedge clk) begin
    if (rst) lamps_q <= '0;
    else     lamps_q <= lamps;
  end

  // FSM, counters and tracking state
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_SYNC;
      phase_r      <= PH_HG;
      phase_cycles <= '0;
      trans_cnt    <= '0;
      first        <= 1'b0;
      phase_valid  <= 1'b0;
    end else begin
      state        <= state_n;
      phase_r      <= phase_n;
      phase_cycles <= cyc_n;
      trans_cnt    <= trans_n;
      first        <= first_n;
      phase_valid  <= valid_n;
    end
  end

  // Next-state logic; error events are one-cycle pulses into the sticky flags
  always_comb begin
    state_n  = state;
    phase_n  = phase_r;
    cyc_n    = phase_cycles;
    trans_n  = trans_cnt;
    first_n  = first;
    valid_n  = phase_valid;
    ev_code  = 1'b0;
    ev_seq   = 1'b0;
    ev_short = 1'b0;
    ev_stall = 1'b0;
    case (state)
      ST_SYNC: begin
        // Dark or garbage lamps at power-up are expected, so no error here
        if (dec_legal) begin
          state_n = ST_TRACK;
          phase_n = dec_phase;
          cyc_n   = CYC_ONE;
          first_n = 1'b1;
          valid_n = 1'b1;
        end
      end
      default: begin
        if (!dec_legal) begin
          ev_code = 1'b1;
          state_n = ST_SYNC;
          valid_n = 1'b0;
          cyc_n   = '0;
        end else if (dec_phase == phase_r) begin
          if (phase_cycles != CYC_MAX) cyc_n = phase_cycles + CYC_ONE;
`ifdef TLC_MON_STALL_EN
          if (32'(cyc_n) >= MAX_PHASE) ev_stall = 1'b1;
`endif
        end else if (dec_phase == next_phase(phase_r)) begin
          trans_n = trans_cnt + 1'b1;
          phase_n = dec_phase;
          cyc_n   = CYC_ONE;
          first_n = 1'b0;
          // The phase entered from SYNC may be partial, so it is not timed
          if (!first &&
              32'(phase_cycles) < min_cycles(phase_r, MIN_GREEN, MIN_YELLOW))
            ev_short = 1'b1;
        end else begin
          ev_seq  = 1'b1;
          phase_n = dec_phase;
          cyc_n   = CYC_ONE;
          first_n = 1'b1;
        end
      end
    endcase
  end

  // Sticky error flags: clr clears, a same-cycle new event wins
  always_ff @(posedge clk) begin
    if (rst) begin
      err_code  <= 1'b0;
      err_seq   <= 1'b0;
      err_short <= 1'b0;
    end else begin
      err_code  <= (err_code  & ~clr) | ev_code;
      err_seq   <= (err_seq   & ~clr) | ev_seq;
      err_short <= (err_short & ~clr) | ev_short;
    end
  end

`ifdef TLC_MON_STALL_EN
  // Sticky stall flag
  always_ff @(posedge clk) begin
    if (rst) err_stall <= 1'b0;
    else     err_stall <= (err_stall & ~clr) | ev_stall;
  end
`else
  assign err_stall = 1'b0;
  logic unused_stall;
  assign unused_stall = ev_stall;
`endif

endmodule

// File: tb/tb_tlc_phase_monitor.sv
// Directed testbench for tlc_phase_monitor.
// Build option: define TLC_MON_STALL_EN to expect the stall flag behaviour.
module tb_tlc_phase_monitor;

  localparam int CNT_W   = 8;
  localparam int TRANS_W = 16;

  localparam logic [5:0] L_HG  = 6'b100001;
  localparam logic [5:0] L_HY  = 6'b100010;
  localparam logic [5:0] L_FG  = 6'b001100;
  localparam logic [5:0] L_FY  = 6'b010100;
  localparam logic [5:0] L_BAD = 6'b000011;

  logic               clk = 1'b0;
  logic               rst;
  logic [5:0]         lamps;
  logic               clr;
  logic               phase_valid;
  logic [1:0]         phase;
  logic [CNT_W-1:0]   phase_cycles;
  logic [TRANS_W-1:0] trans_cnt;
  logic               err_code, err_seq, err_short, err_stall;

  int errors = 0;
  int checks = 0;

  tlc_phase_monitor #(
    .CNT_W      (CNT_W),
    .TRANS_W    (TRANS_W),
    .MIN_GREEN  (4),
    .MIN_YELLOW (3),
    .MAX_PHASE  (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .lamps        (lamps),
    .clr          (clr),
    .phase_valid  (phase_valid),
    .phase        (phase),
    .phase_cycles (phase_cycles),
    .trans_cnt    (trans_cnt),
    .err_code     (err_code),
    .err_seq      (err_seq),
    .err_short    (err_short),
    .err_stall    (err_stall)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one lamp value for n cycles; outputs sampled 1ns after each edge
  task automatic step(input logic [5:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      lamps = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    lamps = '0;
    clr   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_errs(input string tag, input logic c, input logic s,
                          input logic sh);
    chk({tag, "_err_code"},  32'(err_code),  32'(c));
    chk({tag, "_err_seq"},   32'(err_seq),   32'(s));
    chk({tag, "_err_short"}, 32'(err_short), 32'(sh));
  endtask

  initial begin
    rst = 1'b1; lamps = '0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 32'(phase_valid), 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_cycles", 32'(phase_cycles), 0);
    chk("rst_trans", 32'(trans_cnt), 0);
    chk_errs("rst", 0, 0, 0);
    chk("rst_stall", 32'(err_stall), 0);

    // Dark lamps keep the monitor in SYNC without errors
    step('0, 5);
    chk("dark_valid", 32'(phase_valid), 0);
    chk("dark_trans", 32'(trans_cnt), 0);
    chk_errs("dark", 0, 0, 0);

    // Full legal cycle with minimum durations
    step(L_HG, 4); step(L_HY, 3); step(L_FG, 4); step(L_FY, 3); step(L_HG, 1);
    chk("cyc_fy_phase", 32'(phase), 3);
    chk("cyc_fy_cycles", 32'(phase_cycles), 3);
    chk("cyc_fy_trans", 32'(trans_cnt), 3);
    step(L_HG, 1);
    chk("cyc_hg_phase", 32'(phase), 0);
    chk("cyc_hg_cycles", 32'(phase_cycles), 1);
    chk("cyc_hg_trans", 32'(trans_cnt), 4);
    chk("cyc_hg_valid", 32'(phase_valid), 1);
    chk_errs("cyc", 0, 0, 0);

    // HG held only 2 cycles before HY -> short phase
    step(L_HY, 1);
    chk("short_pre_cycles", 32'(phase_cycles), 2);
    chk("short_pre_err", 32'(err_short), 0);
    step(L_HY, 1);
    chk("short_phase", 32'(phase), 1);
    chk("short_trans", 32'(trans_cnt), 5);
    chk_errs("short", 0, 0, 1);

    // First phase after SYNC is exempt from timing
    do_reset();
    step(L_HG, 1); step(L_HY, 3); step(L_FG, 1);
    chk("exempt_phase", 32'(phase), 1);
    chk("exempt_cycles", 32'(phase_cycles), 3);
    chk("exempt_trans", 32'(trans_cnt), 1);
    chk_errs("exempt", 0, 0, 0);

    // Out-of-sequence legal phase, then an illegal code, then clr
    do_reset();
    step(L_HG, 5); step(L_FG, 1);
    chk("seq_pre_cycles", 32'(phase_cycles), 5);
    step(L_BAD, 1);
    chk("seq_phase", 32'(phase), 2);
    chk("seq_cycles", 32'(phase_cycles), 1);
    chk("seq_trans", 32'(trans_cnt), 0);
    chk_errs("seq", 0, 1, 0);
    step(L_BAD, 1);
    chk("code_valid", 32'(phase_valid), 0);
    chk("code_phase", 32'(phase), 2);
    chk("code_cycles", 32'(phase_cycles), 0);
    chk_errs("code", 1, 1, 0);
    clr = 1'b1;
    step('0, 1);
    clr = 1'b0;
    chk_errs("clr", 0, 0, 0);

    // clr on the same edge a sequence error is detected: error wins
    step(L_HG, 2); step(L_FG, 1);
    chk("race_pre_seq", 32'(err_seq), 0);
    clr = 1'b1;
    step(L_FG, 1);
    clr = 1'b0;
    chk("race_seq", 32'(err_seq), 1);
    chk("race_phase", 32'(phase), 2);
    clr = 1'b1;
    step(L_FG, 1);
    clr = 1'b0;
    chk("race_clr_seq", 32'(err_seq), 0);

    // Long HG hold: stall flag and counter saturation
    do_reset();
    step(L_HG, 10);
    chk("stall_cycles9", 32'(phase_cycles), 9);
    chk("stall_pre", 32'(err_stall), 0);
    step(L_HG, 1);
    chk("stall_cycles10", 32'(phase_cycles), 10);
`ifdef TLC_MON_STALL_EN
    chk("stall_at10", 32'(err_stall), 1);
`else
    chk("stall_at10", 32'(err_stall), 0);
`endif
    step(L_HG, 2);
    chk("stall_cycles12", 32'(phase_cycles), 12);
`ifdef TLC_MON_STALL_EN
    chk("stall_sticky", 32'(err_stall), 1);
`else
    chk("stall_sticky", 32'(err_stall), 0);
`endif
    step(L_HG, 250);
    chk("sat_cycles", 32'(phase_cycles), 255);
    step(L_HY, 2);
    chk("sat_trans", 32'(trans_cnt), 1);
    chk("sat_phase", 32'(phase), 1);
    chk_errs("sat", 0, 0, 0);
    clr = 1'b1;
    step(L_HY, 1);
    clr = 1'b0;
    chk("stall_clr", 32'(err_stall), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlc_phase_monitor.md
Name: tlc_phase_monitor

Overview:
- Receiving end of the traffic-light controller's lamp interface: consumes the six lamp outputs (highway and farm-road red/yellow/green).
- Decodes them into a phase, times each phase, and checks the legal sequence HG -> HY -> FG -> FY -> HG.
- Raises sticky error flags and keeps transition statistics.
- Sits beside the controller in emulation/FPGA test builds as an on-chip checker.

Parameters:
- CNT_W, 8, width of the phase-duration counter (saturating).
- TRANS_W, 16, width of the transition counter (wrapping).
- MIN_GREEN, 4, minimum legal cycles in HG or FG.
- MIN_YELLOW, 3, minimum legal cycles in HY or FY.
- MAX_PHASE, 200, stall limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- lamps  in  6  {fr_r, fr_y, fr_g, hw_r, hw_y, hw_g}
- clr  in  1  clears sticky error flags
- phase_valid  out  1  monitor is locked to a legal phase
- phase  out  2  HG=0, HY=1, FG=2, FY=3
- phase_cycles  out  CNT_W  cycles spent in the current phase
- trans_cnt  out  TRANS_W  count of legal transitions
- err_code  out  1  sticky: illegal lamp code seen
- err_seq  out  1  sticky: legal code out of sequence
- err_short  out  1  sticky: phase left before its minimum
- err_stall  out  1  sticky: stall flag (optional feature)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0; FSM in SYNC; input register cleared to 0.
- lamps is registered at edge N as lamps_q. Decode and FSM results appear on outputs after edge N+1, so latency is 2 edges.
- Legal codes; any other value is illegal:
  - HG = hw_g & fr_r
  - HY = hw_y & fr_r
  - FG = fr_g & hw_r
  - FY = fr_y & hw_r
- FSM states:
  - SYNC:
    - Legal code -> TRACK. Load phase, set phase_cycles=1, set first=1, set phase_valid=1.
    - Illegal code -> stay; no error raised, since power-up is dark.
  - TRACK, same phase as before: phase_cycles+1, saturating at 2^CNT_W-1.
  - TRACK, next phase in sequence:
    - trans_cnt+1, wrapping.
    - Load the new phase; phase_cycles=1; first=0.
    - If first=0 and phase_cycles < the minimum for the outgoing phase (MIN_GREEN for HG/FG, MIN_YELLOW for HY/FY), set err_short.
  - TRACK, other legal phase: set err_seq; load the new phase; phase_cycles=1; first=1 (timing of the new phase is exempt); trans_cnt unchanged.
  - TRACK, illegal code: set err_code -> SYNC; phase_valid=0; phase_cycles=0; phase holds its last value.
- Errors are sticky. clr clears all err_* on the next edge. If clr coincides with a new error event, the error wins and stays set.
- rst mid-operation returns everything to the reset values on the next edge, with priority over all else.
- Saturated phase_cycles still compares correctly against the minimums; parameters require MIN_* < 2^CNT_W.

Optional Feature:
- Macro: TLC_MON_STALL_EN
- Defined: in TRACK, when phase_cycles reaches MAX_PHASE, err_stall is set and stays sticky. It is cleared by clr or rst. MAX_PHASE must be < 2^CNT_W.
- Undefined: err_stall is tied to 0, and no compare logic is built.

Decomposition:
- Package tlc_mon_pkg:
  - phase enum (HG/HY/FG/FY)
  - FSM state enum (SYNC/TRACK)
  - lamp bit-index constants
  - next_phase function
  - min-duration selector function
- One sub-module, tlc_lamp_decode: combinational lamps -> {legal, phase}.
- The parent holds the input register, FSM, counters and flags.

Test Plan:
- Reset, then lamps=0 for 5 cycles -> phase_valid=0, all err_*=0, trans_cnt=0.
- HG x4, HY x3, FG x4, FY x3, HG -> trans_cnt=4, no errors; phase_cycles=1 two edges after HG returns.
- Locked in HG; then HG x2 followed by HY -> err_short=1. The first phase after SYNC is held only 1 cycle and raises no error.
- HG x5 then FG -> err_seq=1, trans_cnt unchanged. Then lamps=6'b000011 (hw_g+hw_y) -> err_code=1, phase_valid=0. Pulse clr -> all err_* return to 0.
- clr asserted on the same edge a sequence error is detected -> err_seq=1 after that edge.
- TLC_MON_STALL_EN, MAX_PHASE=10: hold HG 12 cycles -> err_stall rises when phase_cycles=10. Without the macro -> err_stall stays 0.
